// File: rtl/tx_arq_controller.sv
// tx_arq_controller: stop-and-wait ARQ transmit sequencer with retries/backoff; define TX_ARQ_STATS_EN for retry/fail counters
module tx_arq_controller #(
  parameter int PKT_W          = 136,
  parameter int RESP_TIMEOUT   = 50000,
  parameter int MAX_RETRY      = 3,
  parameter int BACKOFF_CYCLES = 1000,
  parameter int BUSY_WAIT      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [PKT_W-1:0] pkt_in,
  input  logic             test_mode_in,
  output logic             req_ready,
  output logic [PKT_W-1:0] pkt_out,
  output logic             test_mode_out,
  output logic             tx_start,
  input  logic             tx_busy,
  input  logic             ack,
  input  logic             nak,
  output logic             done,
  output logic             fail,
  output logic [1:0]       attempt,
  output logic [15:0]      retry_total,
  output logic [15:0]      fail_total
);
  localparam int MAX_A = RESP_TIMEOUT > BACKOFF_CYCLES ? RESP_TIMEOUT : BACKOFF_CYCLES;
  localparam int MAX_P = MAX_A > BUSY_WAIT ? MAX_A : BUSY_WAIT;
  localparam int TW    = MAX_P > 1 ? $clog2(MAX_P) : 1;
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, SENDING, WAIT_RESP, BACKOFF, DONE, FAIL} state_t;
  state_t state, state_n;
  logic [TW-1:0] tmr;
  logic tm_q, fail_att, last_try, counting;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    fail_att = (state == WAIT_BUSY && !tx_busy && tmr == TW'(BUSY_WAIT - 1)) ||
               (state == WAIT_RESP && (nak || (!ack && tmr == TW'(RESP_TIMEOUT - 1))));
    last_try = attempt == 2'(MAX_RETRY);
    counting = state == WAIT_BUSY || state == WAIT_RESP || state == BACKOFF;
    state_n = state;
    case (state)
      IDLE:      state_n = req ? START : IDLE;
      START:     state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = tx_busy ? SENDING : WAIT_BUSY;
      SENDING:   state_n = tx_busy ? SENDING : WAIT_RESP;
      WAIT_RESP: state_n = ack && !nak ? DONE : WAIT_RESP;
      BACKOFF:   state_n = tmr == TW'(BACKOFF_CYCLES - 1) ? START : BACKOFF;
      default:   state_n = IDLE;
    endcase
    if (fail_att) state_n = last_try ? FAIL : BACKOFF;
  end
  always_comb begin
    req_ready     = state == IDLE && !rst;
    tx_start      = state == START;
    done          = state == DONE;
    fail          = state == FAIL;
    test_mode_out = tm_q && attempt == 2'd0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      tmr     <= '0;
      attempt <= '0;
      pkt_out <= '0;
      tm_q    <= 1'b0;
    end else begin
      tmr <= (counting && state_n == state) ? tmr + TW'(1) : '0;
      if (state == IDLE && req) begin
        pkt_out <= pkt_in;
        tm_q    <= test_mode_in;
        attempt <= '0;
      end else if (fail_att && !last_try) begin
        attempt <= attempt + 2'd1;
      end
    end
`ifdef TX_ARQ_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      retry_total <= '0;
      fail_total  <= '0;
    end else begin
      if (state_n == BACKOFF && state != BACKOFF && retry_total != 16'hFFFF) retry_total <= retry_total + 16'd1;
      if (state_n == FAIL && state != FAIL && fail_total != 16'hFFFF) fail_total <= fail_total + 16'd1;
    end
`else
  assign retry_total = '0;
  assign fail_total  = '0;
`endif
endmodule
